hit_response_controller: RTL and testbench
==========================================

HIT_RESPONSE_CONTROLLER -- requirements
Module: hit_response_controller

Interface
REQ-001 Parameter INIT_LIVES, default 3: lives loaded on reset and on game start.
REQ-002 Parameter MAX_LIVES, default 7: lives saturation ceiling.
REQ-003 Parameter INVUL_FRAMES, default 60: frame count of post-hit invulnerability.
REQ-004 Parameter COIN_POINTS, default 10: BCD points added per coin event.
REQ-005 Parameter RING_POINTS, default 100: BCD points added per good-collision event.
REQ-006 The block SHALL have one clock and an asynchronous, active-high reset, with the following ports.
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- hit_type  in  3  per-pixel code: 0 no_hit, 1 life, 2 coin, 3 good_collision, 4 bad_collision; 5-7 are treated as 0.
- startOfFrame  in  1  one-clk pulse at frame start.
- start_game  in  1  level, sampled in IDLE and GAME_OVER.
- lives  out  3  remaining lives.
- score  out  16  four BCD digits, score[15:12] most significant.
- game_state  out  2  0 IDLE, 1 PLAY, 2 HURT, 3 GAME_OVER.
- invulnerable  out  1  high in HURT.
- hit_flash  out  1  one-clk pulse when a bad hit is applied.

Function
REQ-007 During a frame, in PLAY or HURT, any clk with hit_type==1/2/3/4 SHALL set the matching sticky flag (life_f, coin_f, good_f, bad_f); flags SHALL be cleared on the clk they are applied.
REQ-008 On startOfFrame the flags SHALL be applied once, so each class counts at most once per frame regardless of pixel count; outputs update one clk after startOfFrame.
REQ-009 A hit on the same clk as startOfFrame SHALL belong to the next frame.
REQ-010 good_f SHALL score only on a rising edge: it scores if good was not applied in the previous frame (register prev_good).
REQ-011 coin_f and life_f SHALL score every frame in which they are set (the sprite disappears upstream).
REQ-012 Score add SHALL be BCD with carry per digit; a result above 9999 SHALL saturate at 9999.
REQ-013 life_f SHALL increment lives, saturating at MAX_LIVES.
REQ-014 In PLAY, bad_f SHALL decrement lives, pulse hit_flash, and move to HURT with frame counter = INVUL_FRAMES.
REQ-015 If lives==1 when bad_f is applied, lives SHALL become 0 and the state SHALL become GAME_OVER instead of HURT.
REQ-016 In HURT, bad_f SHALL be discarded, while coin, life, and good events still apply.
REQ-017 In HURT, the counter SHALL decrement at each startOfFrame; at 0 the state SHALL become PLAY on that same startOfFrame.
REQ-018 When bad_f and life_f are set in the same frame, life SHALL be applied first and then bad; the net lives change is 0 unless lives==MAX_LIVES.
REQ-019 IDLE->PLAY and GAME_OVER->PLAY on start_game==1 SHALL reload lives=INIT_LIVES, set score=0, and clear flags, prev_good, and counter.
REQ-020 In IDLE and GAME_OVER, hit_type SHALL be ignored and no flags set.
REQ-021 startOfFrame asserted for more than one clk SHALL apply flags once only (edge-detected).

Reset
REQ-022 While reset is high, the block SHALL hold game_state=IDLE, lives=INIT_LIVES, score=0, invulnerable=0, hit_flash=0, and all flags, prev_good, and counter at 0.
REQ-023 Reset SHALL take effect asynchronously mid-frame or mid-HURT, and pending flags SHALL be lost.

Configuration
REQ-024 With macro EXTRA_LIFE_EN defined, a score update that crosses a thousands boundary (digit 3 changes) SHALL also increment lives, saturating at MAX_LIVES, in the same update.
REQ-025 Without EXTRA_LIFE_EN, lives SHALL change only via life and bad events, and no thousands-crossing logic SHALL exist.

Verification
REQ-026 Reset, start_game=1, then 50 clks of hit_type=2 in one frame, then startOfFrame -> score=0x0010 once, lives=3.
REQ-027 hit_type=3 in three consecutive frames, then none, then 3 again -> score increments 0x0100 twice total (frames 1 and 5).
REQ-028 With lives=1 in PLAY, hit_type=4, then startOfFrame -> lives=0, game_state=3, hit_flash pulses once; start_game -> lives=3, score=0, game_state=1.
REQ-029 With INVUL_FRAMES=2, a bad hit and then bad hits every frame -> lives drop 3->2, stay 2 for two frames, then drop 2->1 on the first frame after return to PLAY.
REQ-030 Score 0x9995 plus a coin -> 0x9999 (saturated); with EXTRA_LIFE_EN, score 0x0995 plus a coin -> 0x1005 and lives 3->4.
REQ-031 Assert reset mid-HURT with flags set -> immediate IDLE, lives=INIT_LIVES, and no score change after release.

Source files
------------

// File: rtl/hit_response_controller.sv
// Hit response controller: folds per-pixel hit codes into once-per-frame score/lives updates.
// Optional feature macro EXTRA_LIFE_EN: a life is awarded when the score thousands digit changes.
module hit_response_controller #(
  parameter int INIT_LIVES   = 3,
  parameter int MAX_LIVES    = 7,
  parameter int INVUL_FRAMES = 60,
  parameter int COIN_POINTS  = 10,
  parameter int RING_POINTS  = 100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  hit_type,
  input  logic        startOfFrame,
  input  logic        start_game,
  output logic [2:0]  lives,
  output logic [15:0] score,
  output logic [1:0]  game_state,
  output logic        invulnerable,
  output logic        hit_flash
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_HURT = 2'd2,
    S_OVER = 2'd3
  } state_e;

  localparam int CNT_W =
    (INVUL_FRAMES < 2) ? 1 : $clog2(INVUL_FRAMES + 1);

  localparam logic [2:0] INIT_L = 3'(INIT_LIVES);
  localparam logic [2:0] MAX_L  = 3'(MAX_LIVES);
  localparam logic [CNT_W-1:0] INVUL_C = CNT_W'(INVUL_FRAMES);

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int t;
    r = '0;
    t = v;
    for (int i = 0; i < 4; i++) begin
      r[i*4 +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  localparam logic [15:0] COIN_BCD = to_bcd(COIN_POINTS);
  localparam logic [15:0] RING_BCD = to_bcd(RING_POINTS);

  // Digit-serial BCD add; a carry out of the top digit pins at 9999.
  function automatic logic [15:0] bcd_add_sat(
    input logic [15:0] a,
    input logic [15:0] b
  );
    logic [15:0] r;
    logic [4:0]  s;
    logic        c;
    r = '0;
    c = 1'b0;
    for (int i = 0; i < 4; i++) begin
      s = 5'(a[i*4 +: 4]) + 5'(b[i*4 +: 4]) + 5'(c);
      if (s > 5'd9) begin
        s = s - 5'd10;
        c = 1'b1;
      end else begin
        c = 1'b0;
      end
      r[i*4 +: 4] = s[3:0];
    end
    if (c) r = 16'h9999;
    return r;
  endfunction

  function automatic logic [2:0] inc_sat(input logic [2:0] l);
    return (l >= MAX_L) ? MAX_L : l + 3'd1;
  endfunction

  state_e             state_q, state_d;
  logic [2:0]         lives_q, lives_d;
  logic [15:0]        score_q, score_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               life_f_q, life_f_d;
  logic               coin_f_q, coin_f_d;
  logic               good_f_q, good_f_d;
  logic               bad_f_q, bad_f_d;
  logic               prev_good_q, prev_good_d;
  logic               sof_q, sof_d;
  logic               flash_q, flash_d;

  logic hit_life, hit_coin, hit_good, hit_bad;

  always_comb begin
    hit_life = 1'b0;
    hit_coin = 1'b0;
    hit_good = 1'b0;
    hit_bad  = 1'b0;
    unique case (hit_type)
      3'd1:    hit_life = 1'b1;
      3'd2:    hit_coin = 1'b1;
      3'd3:    hit_good = 1'b1;
      3'd4:    hit_bad  = 1'b1;
      default: ;
    endcase
  end

  logic        sof_edge;
  logic [15:0] sc;
  logic [2:0]  lv;

  assign sof_edge = startOfFrame & ~sof_q;

  always_comb begin
    state_d     = state_q;
    lives_d     = lives_q;
    score_d     = score_q;
    cnt_d       = cnt_q;
    life_f_d    = life_f_q;
    coin_f_d    = coin_f_q;
    good_f_d    = good_f_q;
    bad_f_d     = bad_f_q;
    prev_good_d = prev_good_q;
    sof_d       = startOfFrame;
    flash_d     = 1'b0;
    sc          = score_q;
    lv          = lives_q;

    unique case (state_q)
      S_IDLE, S_OVER: begin
        if (start_game) begin
          state_d     = S_PLAY;
          lives_d     = INIT_L;
          score_d     = '0;
          cnt_d       = '0;
          life_f_d    = 1'b0;
          coin_f_d    = 1'b0;
          good_f_d    = 1'b0;
          bad_f_d     = 1'b0;
          prev_good_d = 1'b0;
        end
      end
      S_PLAY, S_HURT: begin
        if (sof_edge) begin
          if (coin_f_q) sc = bcd_add_sat(sc, COIN_BCD);
          if (good_f_q && !prev_good_q) sc = bcd_add_sat(sc, RING_BCD);
          if (life_f_q) lv = inc_sat(lv);
`ifdef EXTRA_LIFE_EN
          if (sc[15:12] != score_q[15:12]) lv = inc_sat(lv);
`else
`endif
          // Life is credited before a bad hit is charged.
          if (state_q == S_PLAY) begin
            if (bad_f_q) begin
              flash_d = 1'b1;
              if (lv <= 3'd1) begin
                lv      = '0;
                state_d = S_OVER;
              end else begin
                lv      = lv - 3'd1;
                state_d = S_HURT;
                cnt_d   = INVUL_C;
              end
            end
          end else begin
            if (cnt_q <= CNT_W'(1)) begin
              cnt_d   = '0;
              state_d = S_PLAY;
            end else begin
              cnt_d = cnt_q - CNT_W'(1);
            end
          end
          score_d     = sc;
          lives_d     = lv;
          prev_good_d = good_f_q;
          // A hit on the frame-start clock opens the next frame.
          life_f_d    = hit_life;
          coin_f_d    = hit_coin;
          good_f_d    = hit_good;
          bad_f_d     = hit_bad;
        end else begin
          life_f_d = life_f_q | hit_life;
          coin_f_d = coin_f_q | hit_coin;
          good_f_d = good_f_q | hit_good;
          bad_f_d  = bad_f_q  | hit_bad;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      lives_q     <= INIT_L;
      score_q     <= '0;
      cnt_q       <= '0;
      life_f_q    <= 1'b0;
      coin_f_q    <= 1'b0;
      good_f_q    <= 1'b0;
      bad_f_q     <= 1'b0;
      prev_good_q <= 1'b0;
      sof_q       <= 1'b0;
      flash_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      lives_q     <= lives_d;
      score_q     <= score_d;
      cnt_q       <= cnt_d;
      life_f_q    <= life_f_d;
      coin_f_q    <= coin_f_d;
      good_f_q    <= good_f_d;
      bad_f_q     <= bad_f_d;
      prev_good_q <= prev_good_d;
      sof_q       <= sof_d;
      flash_q     <= flash_d;
    end
  end

  assign lives        = lives_q;
  assign score        = score_q;
  assign game_state   = state_q;
  assign invulnerable = (state_q == S_HURT);
  assign hit_flash    = flash_q;

endmodule

// File: tb/tb_hit_response_controller.sv
// Bench for hit_response_controller: directed scenarios plus a random run
// checked against a decimal-arithmetic game model.
module tb_hit_response_controller;

  localparam int INIT = 3;
  localparam int MAXL = 7;
  localparam int INV  = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  hit_type = 3'd0;
  logic        startOfFrame = 1'b0;
  logic        start_game = 1'b0;
  logic [2:0]  lives;
  logic [15:0] score;
  logic [1:0]  game_state;
  logic        invulnerable;
  logic        hit_flash;

  int n_run = 0;
  int n_fail = 0;

  hit_response_controller #(
    .INIT_LIVES(INIT), .MAX_LIVES(MAXL), .INVUL_FRAMES(INV),
    .COIN_POINTS(10), .RING_POINTS(100)
  ) dut (
    .clk(clk), .reset(reset), .hit_type(hit_type),
    .startOfFrame(startOfFrame), .start_game(start_game),
    .lives(lives), .score(score), .game_state(game_state),
    .invulnerable(invulnerable), .hit_flash(hit_flash)
  );

  always #5 clk = ~clk;

  // Game model: 0 idle, 1 play, 2 hurt, 3 game over; score as plain integer.
  int m_state, m_lives, m_score, m_cnt;
  bit m_life, m_coin, m_good, m_bad, m_prev_good, m_sof, m_flash;

  function automatic logic [15:0] bcd(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic void m_reset();
    m_state = 0; m_lives = INIT; m_score = 0; m_cnt = 0;
    m_life = 0; m_coin = 0; m_good = 0; m_bad = 0;
    m_prev_good = 0; m_sof = 0; m_flash = 0;
  endfunction

  function automatic void m_step(input logic [2:0] h, input logic s, input logic g);
    bit fe;
    int old, add;
    fe = s && !m_sof;
    m_sof = s;
    m_flash = 0;
    if (m_state == 0 || m_state == 3) begin
      if (g) begin
        m_state = 1; m_lives = INIT; m_score = 0; m_cnt = 0;
        m_life = 0; m_coin = 0; m_good = 0; m_bad = 0; m_prev_good = 0;
      end
    end else if (fe) begin
      old = m_score;
      add = 0;
      if (m_coin) add += 10;
      if (m_good && !m_prev_good) add += 100;
      m_score = (m_score + add > 9999) ? 9999 : m_score + add;
      m_prev_good = m_good;
      if (m_life && m_lives < MAXL) m_lives++;
`ifdef EXTRA_LIFE_EN
      if (old / 1000 != m_score / 1000 && m_lives < MAXL) m_lives++;
`else
`endif
      if (m_state == 1) begin
        if (m_bad) begin
          m_flash = 1;
          if (m_lives <= 1) begin m_lives = 0; m_state = 3; end
          else begin m_lives--; m_state = 2; m_cnt = INV; end
        end
      end else begin
        m_cnt--;
        if (m_cnt <= 0) begin m_cnt = 0; m_state = 1; end
      end
      m_life = (h == 1); m_coin = (h == 2); m_good = (h == 3); m_bad = (h == 4);
    end else begin
      m_life |= (h == 1); m_coin |= (h == 2); m_good |= (h == 3); m_bad |= (h == 4);
    end
  endfunction

  task automatic step(input logic [2:0] h, input logic s, input logic g);
    hit_type = h; startOfFrame = s; start_game = g;
    @(posedge clk);
    m_step(h, s, g);
    #1;
  endtask

  task automatic frame(input logic [2:0] h1, input logic [2:0] h2);
    step(h1, 1'b0, 1'b0);
    step(h2, 1'b0, 1'b0);
    step(3'd0, 1'b1, 1'b0);
  endtask

  task automatic do_reset();
    hit_type = 0; startOfFrame = 0; start_game = 0;
    reset = 1'b1;
    m_reset();
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    reset = 1'b1;
    #3;
    n_run++; if (game_state !== 2'd0) begin n_fail++; $display("FAIL reset_state got=%0d exp=0", game_state); end
    n_run++; if (lives !== 3'd3) begin n_fail++; $display("FAIL reset_lives got=%0d exp=3", lives); end
    n_run++; if (score !== 16'h0000) begin n_fail++; $display("FAIL reset_score got=%h exp=0000", score); end
    n_run++; if (invulnerable !== 1'b0 || hit_flash !== 1'b0) begin n_fail++; $display("FAIL reset_flags got=%b%b exp=00", invulnerable, hit_flash); end
    do_reset();
    frame(3'd2, 3'd3);
    frame(3'd4, 3'd1);
    n_run++; if (score !== 16'h0000 || game_state !== 2'd0 || lives !== 3'd3) begin n_fail++; $display("FAIL idle_ignore got=%h/%0d/%0d exp=0000/0/3", score, game_state, lives); end
  endtask

  task automatic test_coin();
    do_reset();
    step(3'd0, 1'b0, 1'b1);
    n_run++; if (game_state !== 2'd1) begin n_fail++; $display("FAIL start_play got=%0d exp=1", game_state); end
    for (int i = 0; i < 50; i++) step(3'd2, 1'b0, 1'b0);
    step(3'd0, 1'b1, 1'b0);
    n_run++; if (score !== 16'h0010 || lives !== 3'd3) begin n_fail++; $display("FAIL coin_once got=%h/%0d exp=0010/3", score, lives); end
    frame(3'd0, 3'd0);
    n_run++; if (score !== 16'h0010) begin n_fail++; $display("FAIL coin_cleared got=%h exp=0010", score); end
  endtask

  task automatic test_ring_edge();
    logic [15:0] exp_s [5];
    logic [2:0]  pat [5];
    exp_s = '{16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0200};
    pat = '{3'd3, 3'd3, 3'd3, 3'd0, 3'd3};
    do_reset();
    step(3'd0, 1'b0, 1'b1);
    for (int f = 0; f < 5; f++) begin
      frame(pat[f], pat[f]);
      n_run++; if (score !== exp_s[f]) begin n_fail++; $display("FAIL ring_frame%0d got=%h exp=%h", f + 1, score, exp_s[f]); end
    end
  endtask

  task automatic test_game_over();
    do_reset();
    step(3'd0, 1'b0, 1'b1);
    frame(3'd2, 3'd0);
    for (int k = 0; k < 2; k++) begin
      frame(3'd4, 3'd0);
      frame(3'd0, 3'd0);
      frame(3'd0, 3'd0);
    end
    n_run++; if (lives !== 3'd1 || game_state !== 2'd1) begin n_fail++; $display("FAIL pre_over got=%0d/%0d exp=1/1", lives, game_state); end
    frame(3'd4, 3'd0);
    n_run++; if (lives !== 3'd0 || game_state !== 2'd3 || hit_flash !== 1'b1) begin n_fail++; $display("FAIL over got=%0d/%0d/%b exp=0/3/1", lives, game_state, hit_flash); end
    step(3'd2, 1'b0, 1'b0);
    n_run++; if (hit_flash !== 1'b0) begin n_fail++; $display("FAIL flash_pulse got=%b exp=0", hit_flash); end
    frame(3'd2, 3'd1);
    n_run++; if (score !== 16'h0010 || lives !== 3'd0 || game_state !== 2'd3) begin n_fail++; $display("FAIL over_ignore got=%h/%0d/%0d exp=0010/0/3", score, lives, game_state); end
    step(3'd0, 1'b0, 1'b1);
    n_run++; if (lives !== 3'd3 || score !== 16'h0000 || game_state !== 2'd1) begin n_fail++; $display("FAIL restart got=%0d/%h/%0d exp=3/0000/1", lives, score, game_state); end
  endtask

  task automatic test_invul();
    logic [2:0] exp_l [4];
    logic [1:0] exp_st [4];
    exp_l = '{3'd2, 3'd2, 3'd2, 3'd1};
    exp_st = '{2'd2, 2'd2, 2'd1, 2'd2};
    do_reset();
    step(3'd0, 1'b0, 1'b1);
    for (int f = 0; f < 4; f++) begin
      frame(3'd4, 3'd4);
      n_run++; if (lives !== exp_l[f] || game_state !== exp_st[f]) begin n_fail++; $display("FAIL invul_frame%0d got=%0d/%0d exp=%0d/%0d", f + 1, lives, game_state, exp_l[f], exp_st[f]); end
      n_run++; if (invulnerable !== (exp_st[f] == 2'd2)) begin n_fail++; $display("FAIL invul_out%0d got=%b", f + 1, invulnerable); end
    end
  endtask

  task automatic test_life_bad();
    do_reset();
    step(3'd0, 1'b0, 1'b1);
    for (int f = 0; f < 5; f++) frame(3'd1, 3'd1);
    n_run++; if (lives !== 3'd7) begin n_fail++; $display("FAIL life_sat got=%0d exp=7", lives); end
    frame(3'd1, 3'd4);
    n_run++; if (lives !== 3'd6 || game_state !== 2'd2) begin n_fail++; $display("FAIL life_bad_max got=%0d/%0d exp=6/2", lives, game_state); end
    frame(3'd2, 3'd1);
    n_run++; if (score !== 16'h0010 || lives !== 3'd7 || game_state !== 2'd2) begin n_fail++; $display("FAIL hurt_events got=%h/%0d/%0d exp=0010/7/2", score, lives, game_state); end
    frame(3'd4, 3'd4);
    n_run++; if (lives !== 3'd7 || game_state !== 2'd1) begin n_fail++; $display("FAIL hurt_discard got=%0d/%0d exp=7/1", lives, game_state); end
    frame(3'd4, 3'd1);
    n_run++; if (lives !== 3'd6 || game_state !== 2'd2) begin n_fail++; $display("FAIL life_then_bad got=%0d/%0d exp=6/2", lives, game_state); end
  endtask

  task automatic test_sof_edge();
    do_reset();
    step(3'd0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) step(3'd2, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(3'd2, 1'b1, 1'b0);
    n_run++; if (score !== 16'h0010) begin n_fail++; $display("FAIL sof_held got=%h exp=0010", score); end
    step(3'd0, 1'b0, 1'b0);
    step(3'd0, 1'b1, 1'b0);
    n_run++; if (score !== 16'h0020) begin n_fail++; $display("FAIL sof_carry got=%h exp=0020", score); end
    step(3'd0, 1'b0, 1'b0);
    step(3'd2, 1'b1, 1'b0);
    n_run++; if (score !== 16'h0020) begin n_fail++; $display("FAIL sof_same_clk got=%h exp=0020", score); end
    step(3'd0, 1'b0, 1'b0);
    step(3'd0, 1'b1, 1'b0);
    n_run++; if (score !== 16'h0030) begin n_fail++; $display("FAIL sof_next_frame got=%h exp=0030", score); end
  endtask

  task automatic test_saturate();
    logic [2:0] exp_l1, exp_l2;
`ifdef EXTRA_LIFE_EN
    exp_l1 = 3'd4; exp_l2 = 3'd7;
`else
    exp_l1 = 3'd3; exp_l2 = 3'd3;
`endif
    do_reset();
    step(3'd0, 1'b0, 1'b1);
    for (int p = 0; p < 8; p++) begin frame(3'd3, 3'd2); frame(3'd2, 3'd0); end
    for (int p = 0; p < 3; p++) frame(3'd2, 3'd0);
    n_run++; if (score !== 16'h0990) begin n_fail++; $display("FAIL bcd_0990 got=%h exp=0990", score); end
    frame(3'd2, 3'd0);
    n_run++; if (score !== 16'h1000 || lives !== exp_l1) begin n_fail++; $display("FAIL bcd_1000 got=%h/%0d exp=1000/%0d", score, lives, exp_l1); end
    for (int p = 0; p < 74; p++) begin frame(3'd3, 3'd2); frame(3'd2, 3'd0); end
    for (int p = 0; p < 11; p++) frame(3'd2, 3'd0);
    n_run++; if (score !== 16'h9990) begin n_fail++; $display("FAIL bcd_9990 got=%h exp=9990", score); end
    frame(3'd2, 3'd0);
    n_run++; if (score !== 16'h9999) begin n_fail++; $display("FAIL sat_coin got=%h exp=9999", score); end
    frame(3'd3, 3'd2);
    n_run++; if (score !== 16'h9999 || lives !== exp_l2) begin n_fail++; $display("FAIL sat_hold got=%h/%0d exp=9999/%0d", score, lives, exp_l2); end
  endtask

  task automatic test_reset_hurt();
    do_reset();
    step(3'd0, 1'b0, 1'b1);
    frame(3'd2, 3'd2);
    frame(3'd4, 3'd0);
    n_run++; if (game_state !== 2'd2 || lives !== 3'd2) begin n_fail++; $display("FAIL rh_hurt got=%0d/%0d exp=2/2", game_state, lives); end
    step(3'd2, 1'b0, 1'b0);
    step(3'd3, 1'b0, 1'b0);
    step(3'd1, 1'b0, 1'b0);
    #3;
    reset = 1'b1;
    m_reset();
    #1;
    n_run++; if (game_state !== 2'd0 || lives !== 3'd3 || score !== 16'h0000 || invulnerable !== 1'b0) begin n_fail++; $display("FAIL rh_async got=%0d/%0d/%h/%b exp=0/3/0000/0", game_state, lives, score, invulnerable); end
    @(posedge clk); #1;
    reset = 1'b0;
    step(3'd0, 1'b1, 1'b0);
    step(3'd0, 1'b0, 1'b0);
    step(3'd0, 1'b1, 1'b0);
    n_run++; if (game_state !== 2'd0 || lives !== 3'd3 || score !== 16'h0000) begin n_fail++; $display("FAIL rh_after got=%0d/%0d/%h exp=0/3/0000", game_state, lives, score); end
  endtask

  task automatic test_random();
    logic [2:0] h;
    logic       s, g;
    do_reset();
    step(3'd0, 1'b0, 1'b1);
    for (int i = 0; i < 1500; i++) begin
      h = 3'($urandom_range(0, 7));
      s = ($urandom_range(0, 3) == 0);
      g = ($urandom_range(0, 15) == 0);
      step(h, s, g);
      n_run++;
      if (lives !== 3'(m_lives) || score !== bcd(m_score) || game_state !== 2'(m_state)
          || invulnerable !== (m_state == 2) || hit_flash !== m_flash) begin
        n_fail++;
        $display("FAIL random_%0d got=%0d/%h/%0d/%b/%b exp=%0d/%h/%0d/%b/%b", i,
                 lives, score, game_state, invulnerable, hit_flash,
                 m_lives, bcd(m_score), m_state, m_state == 2, m_flash);
      end
    end
  endtask

  initial begin
    m_reset();
    test_reset();
    test_coin();
    test_ring_edge();
    test_game_over();
    test_invul();
    test_life_bad();
    test_sof_edge();
    test_saturate();
    test_reset_hurt();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
